axis_lcd_out: RTL
=================

AXIS_LCD_OUT -- requirements
Module: axis_lcd_out

Interface
REQ-001 Parameter H_ACTIVE, 480, active pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 2/41/2, horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, 272, active lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, 2/10/2, vertical front porch, sync and back porch in lines.
REQ-005 Parameter PIX_DIV, 2, clk cycles per pixel (legal range 1..16).
REQ-006 Parameter FIFO_DEPTH, 512, pixel FIFO entries (power of two, 16..4096).
REQ-007 Parameter SYNC_POL, 0, hs/vs active level (0 = active-low).
REQ-008 Parameter UNDER_RGB, 24'h0000FF, colour driven on underflow.
REQ-009 Port clk, in, 1, single clock for all logic; synchronous active-high reset rst.
REQ-010 Port rst, in, 1, synchronous, active-high.
REQ-011 Ports axis_tdata in 32, axis_tvalid in 1, axis_tready out 1, axis_tuser in 1 (SOF), axis_tlast in 1 (EOL).
REQ-012 Port fmt_565, in, 1, pixel format: 0 = tdata[23:0] RGB888; 1 = tdata[15:0] RGB565.
REQ-013 Ports lcd_dclk, lcd_hs, lcd_vs, lcd_en, all out 1; lcd_rgb, out 24.
REQ-014 Ports underflow_o and resync_o, both out 1, sticky flags; clr_flags, in 1, clears both.
REQ-015 Port fifo_level, out $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-016 Pixel tick: a counter divides clk by PIX_DIV; lcd_dclk is high for the first floor(PIX_DIV/2) cycles of each pixel period; when PIX_DIV = 1, lcd_dclk equals ~clk-gated-free tick (constant 1).
REQ-017 hcnt counts 0..H_TOTAL-1 and vcnt counts 0..V_TOTAL-1 on the pixel tick; both wrap; H_TOTAL = sum of the H parameters; V_TOTAL likewise.
REQ-018 Active region is hcnt < H_ACTIVE and vcnt < V_ACTIVE.
REQ-019 hs is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs uses the same rule on vcnt.
REQ-020 lcd_en, lcd_hs, lcd_vs and lcd_rgb are registered; they change one clk after the pixel tick of their hcnt/vcnt.
REQ-021 The FIFO stores {sof, rgb24}; RGB565 expands by MSB replication (R5 to {R5,R5[4:2]}, G6 to {G6,G6[5:4]}, B5 likewise).
REQ-022 axis_tready = !full, and only in state STREAM or SEEK; a beat is accepted on tvalid && tready.
REQ-023 Input FSM state SEEK: accepted beats without tuser are dropped; a beat with tuser is written and moves the FSM to STREAM.
REQ-024 Input FSM state STREAM: every accepted beat is written.
REQ-025 Input FSM state FLUSH: tready = 0; the FIFO is cleared in one cycle; the FSM moves to SEEK next cycle.
REQ-026 Output FSM state WAIT: lcd_en = 0 for the whole frame; at hcnt = vcnt = 0, if the FIFO head has sof = 1, the FSM moves to RUN; otherwise it stays in WAIT.
REQ-027 Output FSM state RUN: one entry is popped per active pixel.
REQ-028 RUN underflow: an active pixel with an empty FIFO drives UNDER_RGB, pops nothing, sets underflow_o, and the FSM stays in RUN.
REQ-029 RUN misalignment: if the popped entry has sof = 1 at a position other than (0,0), or sof = 0 at (0,0), resync_o is set, the input FSM is forced to FLUSH, and the output FSM goes to WAIT.
REQ-030 Blanking pixels drive lcd_rgb = 0 and lcd_en = 0.
REQ-031 tlast is informational only and has no effect on writes.
REQ-032 Simultaneous FIFO push and pop leaves fifo_level unchanged.
REQ-033 A push when full cannot occur, because tready is low when full.
REQ-034 When clr_flags is asserted in the same cycle as a new event, the flag stays set (set wins).

Reset
REQ-035 On rst: all counters = 0, input FSM = SEEK, output FSM = WAIT, FIFO empty, tready = 0 for that cycle, lcd_en = lcd_rgb = 0, hs = vs = inactive level, flags = 0.
REQ-036 Reset asserted mid-frame takes effect on the next clk edge; no partial line is completed.

Structure
REQ-037 A shared package axis_lcd_pkg holds the FSM state enums, the RGB565-to-888 expand function, and the H_TOTAL/V_TOTAL helper.
REQ-038 One sub-module, sync_fifo (parametrised width/depth, flush input, level output, first-word-fall-through head), is instantiated; timing and FSMs are inline.

Verification
REQ-039 Small params (H 4/1/1/1, V 3/1/1/1, PIX_DIV 2); streaming 12 pixels with tuser on the first -> lcd_en is high for 12 ticks, pixels appear in order, hs is low at hcnt = 5, vs is low at vcnt = 4.
REQ-040 Leading 3 beats with tuser = 0 followed by an SOF frame -> the 3 beats are dropped and the first displayed pixel equals the SOF beat.
REQ-041 tvalid stopped after 6 of 12 pixels -> pixels 7..12 show 0x0000FF and underflow_o = 1; clr_flags then clears it.
REQ-042 Second frame carries tuser on its 3rd beat -> resync_o = 1, FIFO is flushed, one blank frame follows, and the next SOF frame displays correctly.
REQ-043 fmt_565 = 1 with tdata = 16'hF800 -> lcd_rgb = 24'hFF0000; with 16'h07E0 -> 24'h00FF00.
REQ-044 FIFO_DEPTH 16 with the sink stalled in blanking -> tready drops at fifo_level 16 and no data is lost; rst asserted mid-line -> all outputs match the reset values next cycle.

Source files
------------

// File: rtl/axis_lcd_out_pkg.sv
// Shared types and helpers for the AXI-Stream to parallel-RGB LCD bridge.
//   in_state_t     : input (stream alignment) FSM states
//   out_state_t    : output (display) FSM states
//   fifo_entry_t   : one FIFO word, start-of-frame marker plus 24-bit colour
//   rgb565_to_888  : widen a 16-bit pixel by replicating each channel's MSBs
//   timing_total   : sum of active + porch + sync for one axis
package axis_lcd_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } in_state_t;

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } out_state_t;

  typedef struct packed {
    logic        sof;
    logic [23:0] rgb;
  } fifo_entry_t;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/axis_lcd_out_if.sv
// AXI-Stream pixel input bundle.
//   tdata  : pixel payload (RGB888 in [23:0] or RGB565 in [15:0])
//   tvalid : source has a beat
//   tready : sink accepts the beat this cycle
//   tuser  : start of frame
//   tlast  : end of line (informational)
interface axis_lcd_out_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_lcd_out_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head.
//   clk, rst    : clock, synchronous active-high reset
//   flush       : empties the FIFO in one cycle (wins over push/pop)
//   push, din   : write side; ignored when full
//   pop, dout   : read side; dout is the current head, pop ignored when empty
//   empty, full : occupancy flags
//   level       : current number of stored entries
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axis_lcd_out.sv
// AXI-Stream video to parallel-RGB LCD driver.
//   clk, rst      : single clock, synchronous active-high reset
//   axis          : pixel stream in (tuser = SOF, tlast ignored)
//   fmt_565       : 0 = RGB888 in tdata[23:0], 1 = RGB565 in tdata[15:0]
//   lcd_dclk      : pixel clock, high for the first half of each pixel period
//   lcd_hs/lcd_vs : syncs, polarity set by SYNC_POL
//   lcd_en/lcd_rgb: data enable and colour, registered on the pixel tick
//   underflow_o   : sticky, an active pixel found the FIFO empty
//   resync_o      : sticky, stream and raster fell out of alignment
//   clr_flags     : clears both sticky flags (a same-cycle event wins)
//   fifo_level    : pixel FIFO occupancy
//
// Input FSM
//   state  | meaning
//   SEEK   | drop beats until one carries SOF, write that one
//   STREAM | write every accepted beat
//   FLUSH  | tready low, FIFO cleared, back to SEEK next cycle
//
// Output FSM
//   state  | meaning
//   WAIT   | display blank; at raster origin start if FIFO head is SOF
//   RUN    | pop one entry per active pixel
module axis_lcd_out
  import axis_lcd_pkg::*;
#(
  parameter int          H_ACTIVE   = 480,
  parameter int          H_FP       = 2,
  parameter int          H_SYNC     = 41,
  parameter int          H_BP       = 2,
  parameter int          V_ACTIVE   = 272,
  parameter int          V_FP       = 2,
  parameter int          V_SYNC     = 10,
  parameter int          V_BP       = 2,
  parameter int          PIX_DIV    = 2,
  parameter int          FIFO_DEPTH = 512,
  parameter bit          SYNC_POL   = 1'b0,
  parameter logic [23:0] UNDER_RGB  = 24'h0000FF
) (
  input  logic                        clk,
  input  logic                        rst,
  axis_lcd_out_if.slave               axis,
  input  logic                        fmt_565,
  output logic                        lcd_dclk,
  output logic                        lcd_hs,
  output logic                        lcd_vs,
  output logic                        lcd_en,
  output logic [23:0]                 lcd_rgb,
  output logic                        underflow_o,
  output logic                        resync_o,
  input  logic                        clr_flags,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  // One spare bit so the sync end bound is representable even with no back porch.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int FIFO_W = $bits(fifo_entry_t);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);
  localparam logic [PW-1:0] DCLK_THR = PW'(PIX_DIV - 1 - PIX_DIV / 2);

  logic [PW-1:0] pix_cnt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          tick;
  logic          active;
  logic          at_origin;
  logic          hs_act;
  logic          vs_act;

  in_state_t     in_state, in_next;
  out_state_t    out_state, out_next;

  logic          tready_int;
  logic          accept;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic          fifo_empty;
  logic          fifo_full;
  fifo_entry_t   fifo_din;
  logic [FIFO_W-1:0] fifo_dout;
  fifo_entry_t   head;

  logic          show_px;
  logic          px_en;
  logic [23:0]   px_rgb;
  logic          set_under;
  logic          set_resync;
  logic          unused_bits;

  assign unused_bits = ^{axis.tlast, axis.tdata[31:24]};

  // Pixel divider: down-counter, the tick is its terminal count. Position in the
  // period is PIX_DIV-1-pix_cnt, so dclk is high while pix_cnt is above DCLK_THR.
  assign tick     = (pix_cnt == '0);
  assign lcd_dclk = (PIX_DIV == 1) ? 1'b1 : (pix_cnt > DCLK_THR);

  always_ff @(posedge clk) begin
    if (rst)       pix_cnt <= '0;
    else if (tick) pix_cnt <= PIX_LAST;
    else           pix_cnt <= pix_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign active    = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign at_origin = (hcnt == '0) && (vcnt == '0);
  assign hs_act    = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_act    = (vcnt >= VS_BEG) && (vcnt < VS_END);

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign head         = fifo_entry_t'(fifo_dout);
  assign fifo_din.sof = axis.tuser;
  assign fifo_din.rgb = fmt_565 ? rgb565_to_888(axis.tdata[15:0]) : axis.tdata[23:0];

  // ---------------- input FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) in_state <= SEEK;
    else     in_state <= in_next;
  end

  always_comb begin
    in_next = in_state;
    if (set_resync) begin
      in_next = FLUSH;
    end else begin
      case (in_state)
        SEEK:    if (accept && axis.tuser) in_next = STREAM;
        STREAM:  in_next = STREAM;
        FLUSH:   in_next = SEEK;
        default: in_next = SEEK;
      endcase
    end
  end

  always_comb begin
    tready_int = !rst && !fifo_full && ((in_state == SEEK) || (in_state == STREAM));
    accept     = axis.tvalid && tready_int;
    fifo_push  = accept && ((in_state == STREAM) || axis.tuser);
    fifo_flush = (in_state == FLUSH);
  end

  assign axis.tready = tready_int;

  // ---------------- output FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) out_state <= WAIT;
    else     out_state <= out_next;
  end

  always_comb begin
    out_next = out_state;
    case (out_state)
      WAIT:    if (tick && at_origin && !fifo_empty && head.sof) out_next = RUN;
      RUN:     if (tick && active && !fifo_empty && (head.sof != at_origin)) out_next = WAIT;
      default: out_next = WAIT;
    endcase
  end

  // Leaving WAIT happens on the origin pixel itself, so that pixel is shown
  // in the same tick rather than costing another frame.
  always_comb begin
    show_px    = tick && active &&
                 ((out_state == RUN) ||
                  ((out_state == WAIT) && at_origin && !fifo_empty && head.sof));
    fifo_pop   = 1'b0;
    px_en      = 1'b0;
    px_rgb     = '0;
    set_under  = 1'b0;
    set_resync = 1'b0;
    if (show_px) begin
      if (fifo_empty) begin
        px_en     = 1'b1;
        px_rgb    = UNDER_RGB;
        set_under = 1'b1;
      end else begin
        fifo_pop = 1'b1;
        if (head.sof != at_origin) begin
          set_resync = 1'b1;
        end else begin
          px_en  = 1'b1;
          px_rgb = head.rgb;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_en  <= 1'b0;
      lcd_rgb <= '0;
      lcd_hs  <= !SYNC_POL;
      lcd_vs  <= !SYNC_POL;
    end else if (tick) begin
      lcd_en  <= px_en;
      lcd_rgb <= px_rgb;
      lcd_hs  <= hs_act ? SYNC_POL : !SYNC_POL;
      lcd_vs  <= vs_act ? SYNC_POL : !SYNC_POL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_o <= 1'b0;
      resync_o    <= 1'b0;
    end else begin
      if (set_under)      underflow_o <= 1'b1;
      else if (clr_flags) underflow_o <= 1'b0;
      if (set_resync)     resync_o    <= 1'b1;
      else if (clr_flags) resync_o    <= 1'b0;
    end
  end

endmodule
